serv_pc_sequencer: RTL

//  Sequences the bit-serial PC/control datapath: fetches an instruction over the ibus, then runs
//  32-cycle serial passes, generating pc_en and the cnt0/cnt2/cnt12to31 strobes the control

---
 rtl/serv_pc_sequencer_pkg.sv | 26 ++
 rtl/serv_bit_counter.sv | 54 +++++
 rtl/serv_pc_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/serv_pc_sequencer_pkg.sv
// Shared definitions for the serial PC/control sequencer: state encoding,
// bit-counter width and the counter values the control datapath strobes on.
package serv_pc_sequencer_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_TRAP   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_IDX0     = 5'd0;
    localparam logic [CNT_W-1:0] CNT_IDX2     = 5'd2;
    localparam logic [CNT_W-1:0] CNT_IDX12    = 5'd12;
    localparam logic [CNT_W-1:0] CNT_MISALIGN = 5'd1;
    localparam logic [CNT_W-1:0] CNT_LAST     = 5'd31;

    // Upper-field window of the serial word (bits 12..31 of the immediate/PC).
    function automatic logic cnt_in_upper(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_IDX12);
    endfunction

endpackage

// File: rtl/serv_bit_counter.sv
// Five-bit serial bit counter: advances once per unstalled pass cycle, wraps
// after bit 31 and decodes the position strobes consumed by the control path.
module serv_bit_counter
    import serv_pc_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_active,
    input  logic             i_stall,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt0,
    output logic             o_cnt2,
    output logic             o_cnt12to31,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt_r;
    logic             advance_s;

    assign advance_s = i_active & ~i_stall;
    assign o_cnt     = cnt_r;

    // Counter register; wraps from 31 to 0 through natural 5-bit overflow.
    always_ff @(posedge clk) begin
        if (i_rst || i_clr) begin
            cnt_r <= '0;
        end else if (advance_s) begin
            cnt_r <= cnt_r + 5'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Position strobes stay decoded during a stall; done only when advancing.
    always_comb begin
        o_cnt0      = 1'b0;
        o_cnt2      = 1'b0;
        o_cnt12to31 = 1'b0;
        o_done      = 1'b0;
        if (i_active) begin
            o_cnt0      = (cnt_r == CNT_IDX0);
            o_cnt2      = (cnt_r == CNT_IDX2);
            o_cnt12to31 = cnt_in_upper(cnt_r);
            o_done      = (cnt_r == CNT_LAST) & advance_s;
        end else begin
            o_cnt0      = 1'b0;
            o_cnt2      = 1'b0;
            o_cnt12to31 = 1'b0;
            o_done      = 1'b0;
        end
    end

endmodule

// File: rtl/serv_pc_sequencer.sv
// Fetch/decode/serial-pass sequencer for the bit-serial PC datapath, with a
// trap pass inserted when a jump target turns out to be misaligned.
module serv_pc_sequencer
    import serv_pc_sequencer_pkg::*;
#(
    parameter bit WITH_CSR = 1'b1
) (
    input  logic        clk,
    input  logic        i_rst,
    output logic        o_ibus_cyc,
    input  logic        i_ibus_ack,
    input  logic [31:0] i_ibus_rdt,
    output logic [31:0] o_insn,
    output logic        o_decode_valid,
    input  logic        i_jump,
    input  logic        i_bad_pc,
    input  logic        i_stall,
    output logic        o_pc_en,
    output logic        o_cnt0,
    output logic        o_cnt2,
    output logic        o_cnt12to31,
    output logic        o_cnt_done,
    output logic        o_trap
);

    state_e           state_r;
    logic             trap_pend_r;
    logic             ibus_cyc_r;
    logic [31:0]      insn_r;
    logic             pass_active_s;
    logic             misalign_s;
    logic             done_s;
    logic [CNT_W-1:0] cnt_s;

    assign pass_active_s  = (state_r == ST_EXEC) || (state_r == ST_TRAP);
    assign o_pc_en        = pass_active_s & ~i_stall;
    assign o_decode_valid = (state_r == ST_DECODE);
    assign o_trap         = (state_r == ST_TRAP);
    assign o_ibus_cyc     = ibus_cyc_r;
    assign o_insn         = insn_r;
    assign o_cnt_done     = done_s;

    // Bit 1 of the serial target is its first bit that must be zero for a
    // 4-byte aligned jump, so it is sampled at exactly that counter value.
    assign misalign_s = WITH_CSR && (state_r == ST_EXEC) && (cnt_s == CNT_MISALIGN)
                        && !i_stall && i_jump && i_bad_pc;

    serv_bit_counter u_bit_counter (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_clr       (state_r == ST_DECODE),
        .i_active    (pass_active_s),
        .i_stall     (i_stall),
        .o_cnt       (cnt_s),
        .o_cnt0      (o_cnt0),
        .o_cnt2      (o_cnt2),
        .o_cnt12to31 (o_cnt12to31),
        .o_done      (done_s)
    );

    // Sequencer FSM with registered ibus request and instruction latch.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            trap_pend_r <= 1'b0;
            ibus_cyc_r  <= 1'b0;
            insn_r      <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ibus_cyc_r <= 1'b0;
                    state_r    <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (ibus_cyc_r && i_ibus_ack) begin
                        insn_r     <= i_ibus_rdt;
                        ibus_cyc_r <= 1'b0;
                        state_r    <= ST_DECODE;
                    end else begin
                        ibus_cyc_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (misalign_s) begin
                        trap_pend_r <= 1'b1;
                    end
                    if (done_s) begin
                        state_r <= (trap_pend_r || misalign_s) ? ST_TRAP : ST_FETCH;
                    end
                end
                ST_TRAP: begin
                    if (done_s) begin
                        trap_pend_r <= 1'b0;
                        state_r     <= ST_FETCH;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    trap_pend_r <= 1'b0;
                    ibus_cyc_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
